// File: rtl/boot_ram_if.sv
// boot_ram_if: byte-wide bus bundle between the boot loader / CPU core side
// (master) and the boot_ram memory (slave).
//   ld_valid  : loader byte valid               (master -> slave)
//   ld_data   : loader byte                     (master -> slave)
//   ld_last   : marks the final byte of a load  (master -> slave)
//   ld_ready  : memory accepts a loader byte    (slave  -> master)
//   cpu_addr  : core address                    (master -> slave)
//   cpu_wdata : core write data                 (master -> slave)
//   cpu_we    : core write enable               (master -> slave)
//   cpu_rdata : registered read data            (slave  -> master)
interface boot_ram_if;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_we;
  logic [7:0] cpu_rdata;

  modport master (
    output ld_valid, ld_data, ld_last, cpu_addr, cpu_wdata, cpu_we,
    input  ld_ready, cpu_rdata
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, cpu_addr, cpu_wdata, cpu_we,
    output ld_ready, cpu_rdata
  );
endinterface

// File: rtl/boot_ram.sv
// boot_ram: 256x8 program/data memory for the eightbit CPU core with a
// built-in boot loader. After reset (or a reload request) an external byte
// stream is written from address 0 upward, the remainder of memory is then
// zero-filled, and only then is cpu_run raised to release the core.
//   clk      : single clock, rising edge
//   rst      : asynchronous, active-high reset
//   reload   : single-cycle request to restart loading (overrides everything)
//   bus      : loader stream + CPU byte bus (boot_ram_if.slave)
//   cpu_run  : registered, high exactly while memory is valid (RUN state)
//   ld_count : bytes written by the most recent load (0..256)
module boot_ram #(
  parameter int LOAD_LEN = 256  // max bytes per load, 1..256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reload,
  boot_ram_if.slave       bus,
  output logic            cpu_run,
  output logic [8:0]      ld_count
);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_ZERO = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // ld_count value at which the next accepted byte is forced to be final.
  localparam logic [8:0] LAST_COUNT = 9'(LOAD_LEN - 1);

  logic [7:0] mem [256];

  logic [1:0] state_q,     state_d;
  logic [7:0] ptr_q,       ptr_d;
  logic [8:0] ld_count_q,  ld_count_d;
  logic       ld_ready_q,  ld_ready_d;
  logic       cpu_run_q,   cpu_run_d;
  logic [7:0] cpu_rdata_q, cpu_rdata_d;

  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;

  logic       ld_accept;
  logic       ld_final;

  // ld_ready_q is only ever high in LOAD, so it alone qualifies the handshake;
  // ld_last is meaningless without ld_valid because ld_accept gates its use.
  assign ld_accept = ld_ready_q && bus.ld_valid;
  assign ld_final  = bus.ld_last || (ld_count_q == LAST_COUNT);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    ld_count_d  = ld_count_q;
    mem_we      = 1'b0;
    mem_waddr   = ptr_q;
    mem_wdata   = 8'h00;
    cpu_rdata_d = 8'h00;

    if (reload) begin
      // Restart wins over any handshake, ZERO write or CPU access this cycle.
      state_d    = ST_LOAD;
      ptr_d      = 8'h00;
      ld_count_d = 9'd0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (ld_accept) begin
            mem_we     = 1'b1;
            mem_wdata  = bus.ld_data;
            ptr_d      = ptr_q + 8'd1;
            ld_count_d = ld_count_q + 9'd1;
            if (ld_final) begin
              // A final byte at the top address leaves nothing to zero-fill.
              state_d = (ptr_q == 8'hFF) ? ST_RUN : ST_ZERO;
            end
          end
        end

        ST_ZERO: begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + 8'd1;
          if (ptr_q == 8'hFF) begin
            state_d = ST_RUN;
          end
        end

        ST_RUN: begin
          if (bus.cpu_we) begin
            mem_we      = 1'b1;
            mem_waddr   = bus.cpu_addr;
            mem_wdata   = bus.cpu_wdata;
            // Write-first: the read of the address being written sees new data.
            cpu_rdata_d = bus.cpu_wdata;
          end else begin
            cpu_rdata_d = mem[bus.cpu_addr];
          end
        end

        default: begin
          state_d = ST_LOAD;
        end
      endcase
    end

    // Status outputs are registered alongside the state they describe.
    ld_ready_d = (state_d == ST_LOAD);
    cpu_run_d  = (state_d == ST_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      ptr_q       <= 8'h00;
      ld_count_q  <= 9'd0;
      ld_ready_q  <= 1'b0;
      cpu_run_q   <= 1'b0;
      cpu_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ld_count_q  <= ld_count_d;
      ld_ready_q  <= ld_ready_d;
      cpu_run_q   <= cpu_run_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  // NOTE: the array is deliberately not reset; a reset port would prevent RAM
  // inference. The ZERO pass is what gives it defined contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.ld_ready  = ld_ready_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign cpu_run       = cpu_run_q;
  assign ld_count      = ld_count_q;

endmodule

// File: tb/tb_boot_ram.sv
// tb_boot_ram: self-checking bench for boot_ram. Stimulus drives the loader
// and CPU bus; expected read data comes from a plain array model of memory
// and is pushed into a queue when each read is issued. A separate monitor
// pops and compares one cycle later, when cpu_rdata is valid.
module tb_boot_ram;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic       reload = 1'b0;
  logic       cpu_run;
  logic [8:0] ld_count;

  boot_ram_if bus ();

  boot_ram #(.LOAD_LEN(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .reload   (reload),
    .bus      (bus),
    .cpu_run  (cpu_run),
    .ld_count (ld_count)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] exp_q [$];
  logic [7:0] img [$];
  logic       rd_req  = 1'b0;
  logic       rd_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Monitor: a read issued before edge N has its data on cpu_rdata after N.
  always @(posedge clk or posedge rst) begin
    if (rst) rd_seen <= 1'b0;
    else     rd_seen <= rd_req;
  end

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", exp_q.size(), 1);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("cpu_rdata", bus.cpu_rdata, e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ld_valid  = 1'b0;
    bus.ld_data   = 8'h00;
    bus.ld_last   = 1'b0;
    bus.cpu_addr  = 8'h00;
    bus.cpu_wdata = 8'h00;
    bus.cpu_we    = 1'b0;
    rd_req        = 1'b0;
  endtask

  // One CPU bus cycle; the model applies the write before the read (write-first).
  task automatic cpu_access(input logic [7:0] addr, input logic we,
                            input logic [7:0] wdata, input logic do_read);
    bus.cpu_addr  = addr;
    bus.cpu_we    = we;
    bus.cpu_wdata = wdata;
    if (we) ref_mem[addr] = wdata;
    if (do_read) exp_q.push_back(ref_mem[addr]);
    rd_req = do_read;
    tick();
  endtask

  task automatic drain();
    bus.cpu_we = 1'b0;
    rd_req     = 1'b0;
    tick();
    tick();
  endtask

  // Stream img[] through the loader; optional idle gaps carry random ld_last
  // values that must be ignored. Model: image at 0.., zeros above.
  task automatic load_image(input bit use_last, input bit gaps);
    for (int i = 0; i < img.size(); i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'($urandom);
        bus.ld_last  = 1'($urandom);
        tick();
      end
      bus.ld_valid = 1'b1;
      bus.ld_data  = img[i];
      bus.ld_last  = use_last && (i == img.size() - 1);
      tick();
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    for (int a = 0; a < 256; a++) ref_mem[a] = (a < img.size()) ? img[a] : 8'h00;
  endtask

  task automatic wait_run(output int cycles);
    cycles = 0;
    while (!cpu_run && cycles < 1000) begin
      tick();
      cycles++;
    end
    check("cpu_run_timeout", cpu_run, 1'b1);
  endtask

  task automatic read_all();
    for (int a = 0; a < 256; a++) cpu_access(8'(a), 1'b0, 8'h00, 1'b1);
    drain();
  endtask

  initial begin
    int cyc;
    idle();

    // ---- Reset state ----
    #1 rst = 1'b1;
    #2;
    check("rst_ld_ready",  bus.ld_ready,  1'b0);
    check("rst_cpu_run",   cpu_run,       1'b0);
    check("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
    check("rst_ld_count",  ld_count,      9'd0);
    tick();
    tick();
    rst = 1'b0;
    check("ld_ready_before_edge", bus.ld_ready, 1'b0);
    tick();
    check("ld_ready_after_release", bus.ld_ready, 1'b1);

    // ---- Short load; cpu_we held high through LOAD/ZERO must be ignored ----
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 8'h00;
    bus.cpu_wdata = 8'hEE;
    img = '{8'h01, 8'hAA, 8'h02, 8'h40};
    load_image(1'b1, 1'b1);
    check("short_ld_ready_drop", bus.ld_ready,  1'b0);
    check("short_ld_count",      ld_count,      9'd4);
    check("rdata_hold_zero",     bus.cpu_rdata, 8'h00);
    check("short_run_low",       cpu_run,       1'b0);
    wait_run(cyc);
    bus.cpu_we = 1'b0;
    check("short_zero_cycles", cyc, 252);
    foreach (img[i]) cpu_access(8'(i), 1'b0, 8'h00, 1'b1);
    cpu_access(8'd4,   1'b0, 8'h00, 1'b1);
    cpu_access(8'd255, 1'b0, 8'h00, 1'b1);

    // ---- CPU access: same-cycle write/read, then random traffic ----
    cpu_access(8'h10, 1'b1, 8'h5C, 1'b1);
    cpu_access(8'h10, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      cpu_access(a, 1'($urandom), 8'($urandom), 1'b1);
    end
    drain();
    check("run_ld_count_hold", ld_count, 9'd4);

    // ---- Reset mid-RUN: outputs clear asynchronously ----
    cpu_access(8'h20, 1'b1, 8'hA5, 1'b1);
    idle();
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrun_rst_cpu_run",   cpu_run,       1'b0);
    check("midrun_rst_cpu_rdata", bus.cpu_rdata, 8'h00);
    check("midrun_rst_ld_count",  ld_count,      9'd0);
    check("midrun_rst_ld_ready",  bus.ld_ready,  1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("midrun_release_ld_ready", bus.ld_ready, 1'b1);

    // ---- Full load: 256 bytes, no ld_last, RUN directly after byte 255 ----
    img.delete();
    for (int i = 0; i < 256; i++) img.push_back(8'(i));
    load_image(1'b0, 1'b0);
    check("full_cpu_run_direct", cpu_run,      1'b1);
    check("full_ld_count",       ld_count,     9'd256);
    check("full_ld_ready",       bus.ld_ready, 1'b0);
    for (int i = 0; i < 32; i++) cpu_access(8'($urandom), 1'b0, 8'h00, 1'b1);
    drain();

    // ---- Reload from RUN, then a two-byte load ----
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check("reload_cpu_run",  cpu_run,      1'b0);
    check("reload_ld_ready", bus.ld_ready, 1'b1);
    check("reload_ld_count", ld_count,     9'd0);
    img = '{8'($urandom), 8'($urandom)};
    load_image(1'b1, 1'b1);
    wait_run(cyc);
    check("reload_zero_cycles", cyc, 254);
    check("reload2_ld_count", ld_count, 9'd2);
    read_all();

    // ---- Reload collides with a valid handshake: byte dropped ----
    reload = 1'b1;
    tick();
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h77;
    tick();
    reload       = 1'b0;
    bus.ld_valid = 1'b0;
    check("collision_ld_count", ld_count,     9'd0);
    check("collision_ld_ready", bus.ld_ready, 1'b1);
    img = '{8'h33, 8'h44};
    load_image(1'b1, 1'b0);
    wait_run(cyc);
    check("collision_after_ld_count", ld_count, 9'd2);
    for (int a = 0; a < 4; a++) cpu_access(8'(a), 1'b0, 8'h00, 1'b1);
    drain();

    check("scoreboard_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
